// File: rtl/axi_arb_pkg.sv
// Shared types and bus widths for the 2:1 AXI arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int STRB_W = 16;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  // Grant encoding: 0 = M0 (instruction fetch), 1 = M1 (data cache).
  typedef logic gnt_t;
  localparam gnt_t GNT_M0 = 1'b0;
  localparam gnt_t GNT_M1 = 1'b1;

endpackage

// File: rtl/AXIR.sv
// AXI read-side bundle (AR + R channels) between an initiator and a target.
// Latency: n/a (wiring only).
// Backpressure: plain AXI VALID/READY on both channels.
interface AXIR #(parameter int LEN_W = 8);
  import axi_arb_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport target (input  araddr, arlen, arvalid, rready,
                  output arready, rdata, rlast, rvalid);
  modport init   (output araddr, arlen, arvalid, rready,
                  input  arready, rdata, rlast, rvalid);
endinterface

// File: rtl/AXIW.sv
// AXI write-side bundle (AW + W + B channels) between an initiator and a target.
// Latency: n/a (wiring only).
// Backpressure: plain AXI VALID/READY on all three channels.
interface AXIW #(parameter int LEN_W = 8);
  import axi_arb_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport target (input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
                  output awready, wready, bresp, bvalid);
  modport init   (output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
                  input  awready, wready, bresp, bvalid);
endinterface

// File: rtl/arb_pick2.sv
// Two-way winner select for one arbitration point (read or write).
// Latency: purely combinational.
// Backpressure: none; the caller only samples winner while idle.
// Ports: req[1:0] request vector (bit n = Mn), last = previous tie winner,
//        winner = selected master. Macro AXI_ARB_RR_EN selects round-robin
//        on ties; otherwise M0 always wins ties.
module arb_pick2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_t       last,
  output gnt_t       winner
);

`ifdef AXI_ARB_RR_EN
  // On a tie the master that did not win the previous tie goes next.
  assign winner = (req == 2'b11) ? gnt_t'(~last) : gnt_t'(req[1]);
`else
  logic unused_last;
  assign unused_last = last;
  // M0 wins whenever it requests; M1 only when alone.
  assign winner = gnt_t'(req[1] & ~req[0]);
`endif

endmodule

// File: rtl/axi_arbiter_2to1.sv
// Shares one AXI target between M0 (ifetch) and M1 (dcache); read and write arbitrated independently.
// Latency: one idle bubble before address; min 3 cycles single-beat read, 4 cycles single-beat write.
// Backpressure: grant held for the whole transaction; the loser sees READY/VALID = 0 until the FSM returns to idle.
// Ports: CLK, RSTn (async active-low); M0R/M1R/M0W/M1W target-side masters;
//        SR/SW initiator-side to memory. Macro AXI_ARB_RR_EN enables round-robin ties.
module axi_arbiter_2to1
  import axi_arb_pkg::*;
#(
  parameter int LEN_W = 8
)(
  input logic  CLK,
  input logic  RSTn,
  AXIR.target  M0R,
  AXIR.target  M1R,
  AXIW.target  M0W,
  AXIW.target  M1W,
  AXIR.init    SR,
  AXIW.init    SW
);

  // ---------------------------------------------------------------- read side
  rd_state_t r_st;
  gnt_t      r_gnt;
  gnt_t      r_win;
  gnt_t      r_last;
  logic      r_req_any;
  logic      r_tie;
  logic      ar_est;
  logic      r_est;

  assign r_req_any = M0R.arvalid | M1R.arvalid;
  assign r_tie     = M0R.arvalid & M1R.arvalid;

`ifdef AXI_ARB_RR_EN
  gnt_t rr_r;
  assign r_last = rr_r;
  // Only ties move the round-robin pointer.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      rr_r <= GNT_M1;
    else if (r_st == R_IDLE && r_tie)
      rr_r <= r_win;
  end
`else
  logic unused_r_tie;
  assign unused_r_tie = r_tie;
  assign r_last = GNT_M0;
`endif

  arb_pick2 u_pick_r (
    .req    ({M1R.arvalid, M0R.arvalid}),
    .last   (r_last),
    .winner (r_win)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_st  <= R_IDLE;
      r_gnt <= GNT_M0;
    end else begin
      case (r_st)
        R_IDLE: if (r_req_any) begin
          r_gnt <= r_win;
          r_st  <= R_ADDR;
        end
        R_ADDR: if (ar_est) r_st <= R_DATA;
        R_DATA: if (r_est && SR.rlast) r_st <= R_IDLE;
        default: r_st <= R_IDLE;
      endcase
    end
  end

  // Grant mux: payload is muxed freely, handshakes are qualified by state so
  // nothing leaks through while idle.
  assign SR.araddr  = r_gnt ? M1R.araddr : M0R.araddr;
  assign SR.arlen   = r_gnt ? M1R.arlen  : M0R.arlen;
  assign SR.arvalid = (r_st == R_ADDR) & (r_gnt ? M1R.arvalid : M0R.arvalid);
  assign SR.rready  = (r_st == R_DATA) & (r_gnt ? M1R.rready  : M0R.rready);

  assign ar_est = SR.arvalid & SR.arready;
  assign r_est  = SR.rvalid  & SR.rready;

  assign M0R.arready = (r_st == R_ADDR) & (r_gnt == GNT_M0) & SR.arready;
  assign M1R.arready = (r_st == R_ADDR) & (r_gnt == GNT_M1) & SR.arready;
  assign M0R.rvalid  = (r_st == R_DATA) & (r_gnt == GNT_M0) & SR.rvalid;
  assign M1R.rvalid  = (r_st == R_DATA) & (r_gnt == GNT_M1) & SR.rvalid;
  // Data/last are broadcast; only the granted master sees RVALID.
  assign M0R.rdata   = SR.rdata;
  assign M1R.rdata   = SR.rdata;
  assign M0R.rlast   = SR.rlast;
  assign M1R.rlast   = SR.rlast;

  // --------------------------------------------------------------- write side
  wr_state_t        w_st;
  gnt_t             w_gnt;
  gnt_t             w_win;
  gnt_t             w_last;
  logic [LEN_W-1:0] w_cnt;
  logic             w_req_any;
  logic             w_tie;
  logic             aw_est;
  logic             w_est;
  logic             b_est;

  assign w_req_any = M0W.awvalid | M1W.awvalid;
  assign w_tie     = M0W.awvalid & M1W.awvalid;

`ifdef AXI_ARB_RR_EN
  gnt_t rr_w;
  assign w_last = rr_w;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      rr_w <= GNT_M1;
    else if (w_st == W_IDLE && w_tie)
      rr_w <= w_win;
  end
`else
  logic unused_w_tie;
  assign unused_w_tie = w_tie;
  assign w_last = GNT_M0;
`endif

  arb_pick2 u_pick_w (
    .req    ({M1W.awvalid, M0W.awvalid}),
    .last   (w_last),
    .winner (w_win)
  );

  // Burst length comes from AWLEN, not WLAST: the target's beat count is
  // what the response depends on, and WLAST is just forwarded.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      w_st  <= W_IDLE;
      w_gnt <= GNT_M0;
      w_cnt <= '0;
    end else begin
      case (w_st)
        W_IDLE: if (w_req_any) begin
          w_gnt <= w_win;
          w_st  <= W_ADDR;
        end
        W_ADDR: if (aw_est) begin
          w_cnt <= SW.awlen;
          w_st  <= W_DATA;
        end
        W_DATA: if (w_est) begin
          if (w_cnt == '0)
            w_st <= W_RESP;
          else
            w_cnt <= w_cnt - 1'b1;
        end
        W_RESP: if (b_est) w_st <= W_IDLE;
        default: w_st <= W_IDLE;
      endcase
    end
  end

  assign SW.awaddr  = w_gnt ? M1W.awaddr : M0W.awaddr;
  assign SW.awlen   = w_gnt ? M1W.awlen  : M0W.awlen;
  assign SW.awvalid = (w_st == W_ADDR) & (w_gnt ? M1W.awvalid : M0W.awvalid);
  assign SW.wdata   = w_gnt ? M1W.wdata  : M0W.wdata;
  assign SW.wstrb   = w_gnt ? M1W.wstrb  : M0W.wstrb;
  assign SW.wlast   = w_gnt ? M1W.wlast  : M0W.wlast;
  assign SW.wvalid  = (w_st == W_DATA) & (w_gnt ? M1W.wvalid : M0W.wvalid);
  assign SW.bready  = (w_st == W_RESP) & (w_gnt ? M1W.bready : M0W.bready);

  assign aw_est = SW.awvalid & SW.awready;
  assign w_est  = SW.wvalid  & SW.wready;
  assign b_est  = SW.bvalid  & SW.bready;

  assign M0W.awready = (w_st == W_ADDR) & (w_gnt == GNT_M0) & SW.awready;
  assign M1W.awready = (w_st == W_ADDR) & (w_gnt == GNT_M1) & SW.awready;
  assign M0W.wready  = (w_st == W_DATA) & (w_gnt == GNT_M0) & SW.wready;
  assign M1W.wready  = (w_st == W_DATA) & (w_gnt == GNT_M1) & SW.wready;
  assign M0W.bvalid  = (w_st == W_RESP) & (w_gnt == GNT_M0) & SW.bvalid;
  assign M1W.bvalid  = (w_st == W_RESP) & (w_gnt == GNT_M1) & SW.bvalid;
  assign M0W.bresp   = SW.bresp;
  assign M1W.bresp   = SW.bresp;

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Directed bench for axi_arbiter_2to1 with a small always-ready memory target.
// Latency: n/a.
// Backpressure: target is always ready on AR/AW, streams R/W beats back to back.
module tb_axi_arbiter_2to1;
  import axi_arb_pkg::*;

  localparam int LEN_W = 8;
`ifdef AXI_ARB_RR_EN
  localparam logic TIE2_M1_FIRST = 1'b1;
`else
  localparam logic TIE2_M1_FIRST = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  AXIR #(.LEN_W(LEN_W)) m0r(), m1r(), sr();
  AXIW #(.LEN_W(LEN_W)) m0w(), m1w(), sw();

  axi_arbiter_2to1 #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .M0R(m0r), .M1R(m1r), .M0W(m0w), .M1W(m1w),
    .SR(sr), .SW(sw)
  );

  // ---------------------------------------------------------- master drivers
  logic [31:0]  mr_araddr [2];
  logic [7:0]   mr_arlen  [2];
  logic         mr_arvalid[2];
  logic         mr_arready[2];
  logic         mr_rvalid [2];
  logic         mr_rlast  [2];
  logic [127:0] mr_rdata  [2];

  logic [31:0]  mw_awaddr [2];
  logic [7:0]   mw_awlen  [2];
  logic         mw_awvalid[2];
  logic [127:0] mw_wdata  [2];
  logic [15:0]  mw_wstrb  [2];
  logic         mw_wlast  [2];
  logic         mw_wvalid [2];
  logic         mw_awready[2];
  logic         mw_wready [2];
  logic         mw_bvalid [2];
  logic [1:0]   mw_bresp  [2];

  assign m0r.araddr = mr_araddr[0];  assign m1r.araddr = mr_araddr[1];
  assign m0r.arlen  = mr_arlen[0];   assign m1r.arlen  = mr_arlen[1];
  assign m0r.arvalid = mr_arvalid[0]; assign m1r.arvalid = mr_arvalid[1];
  assign m0r.rready = 1'b1;          assign m1r.rready = 1'b1;
  assign mr_arready[0] = m0r.arready; assign mr_arready[1] = m1r.arready;
  assign mr_rvalid[0] = m0r.rvalid;  assign mr_rvalid[1] = m1r.rvalid;
  assign mr_rlast[0]  = m0r.rlast;   assign mr_rlast[1]  = m1r.rlast;
  assign mr_rdata[0]  = m0r.rdata;   assign mr_rdata[1]  = m1r.rdata;

  assign m0w.awaddr = mw_awaddr[0];  assign m1w.awaddr = mw_awaddr[1];
  assign m0w.awlen  = mw_awlen[0];   assign m1w.awlen  = mw_awlen[1];
  assign m0w.awvalid = mw_awvalid[0]; assign m1w.awvalid = mw_awvalid[1];
  assign m0w.wdata  = mw_wdata[0];   assign m1w.wdata  = mw_wdata[1];
  assign m0w.wstrb  = mw_wstrb[0];   assign m1w.wstrb  = mw_wstrb[1];
  assign m0w.wlast  = mw_wlast[0];   assign m1w.wlast  = mw_wlast[1];
  assign m0w.wvalid = mw_wvalid[0];  assign m1w.wvalid = mw_wvalid[1];
  assign m0w.bready = 1'b1;          assign m1w.bready = 1'b1;
  assign mw_awready[0] = m0w.awready; assign mw_awready[1] = m1w.awready;
  assign mw_wready[0] = m0w.wready;  assign mw_wready[1] = m1w.wready;
  assign mw_bvalid[0] = m0w.bvalid;  assign mw_bvalid[1] = m1w.bvalid;
  assign mw_bresp[0]  = m0w.bresp;   assign mw_bresp[1]  = m1w.bresp;

  // ------------------------------------------------------------ memory target
  function automatic logic [127:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(i);
    return {4{w}};
  endfunction

  function automatic logic [127:0] wd(input int seed, input int beat);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(seed) + 32'(beat);
    return {4{w}};
  endfunction

  logic [127:0] mem [256];
  logic       rd_act, wr_act, b_pend;
  logic [7:0] rd_idx, rd_left, wr_idx;

  assign sr.arready = 1'b1;
  assign sr.rvalid  = rd_act;
  assign sr.rlast   = (rd_left == 8'd0);
  assign sr.rdata   = mem[rd_idx];
  assign sw.awready = 1'b1;
  assign sw.wready  = wr_act;
  assign sw.bvalid  = b_pend;
  assign sw.bresp   = 2'b00;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_act <= 1'b0; rd_idx <= 8'd0; rd_left <= 8'd0;
      wr_act <= 1'b0; wr_idx <= 8'd0; b_pend <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else begin
      if (sr.arvalid && sr.arready) begin
        rd_act <= 1'b1; rd_idx <= sr.araddr[11:4]; rd_left <= sr.arlen;
      end else if (sr.rvalid && sr.rready) begin
        if (sr.rlast) rd_act <= 1'b0;
        else begin rd_idx <= rd_idx + 8'd1; rd_left <= rd_left - 8'd1; end
      end
      if (sw.awvalid && sw.awready) begin
        wr_act <= 1'b1; wr_idx <= sw.awaddr[11:4];
      end else if (sw.wvalid && sw.wready) begin
        for (int b = 0; b < 16; b++)
          if (sw.wstrb[b]) mem[wr_idx][8*b +: 8] <= sw.wdata[8*b +: 8];
        wr_idx <= wr_idx + 8'd1;
        if (sw.wlast) begin wr_act <= 1'b0; b_pend <= 1'b1; end
      end
      if (b_pend && sw.bready) b_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- monitors
  int sw_wbeats = 0, m0_bv = 0, m1_rv = 0, m1_early = 0;
  logic mon_blk = 1'b0, m0_done = 1'b0;
  always @(posedge CLK) if (RSTn && sw.wvalid && sw.wready) sw_wbeats++;
  always @(negedge CLK) begin
    if (mw_bvalid[0]) m0_bv++;
    if (mr_rvalid[1]) m1_rv++;
    if (mon_blk && !m0_done && mr_arready[1]) m1_early++;
  end

  // ---------------------------------------------------------------- checking
  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_txn(input int m, input logic [31:0] addr, input logic [7:0] len,
                        output int ar_cyc, output int end_cyc, output int beats,
                        output logic [127:0] first_d, output logic [127:0] last_d);
    int g;
    logic done;
    beats = 0; first_d = '0; last_d = '0; ar_cyc = -1; end_cyc = -1;
    mr_araddr[m] = addr; mr_arlen[m] = len; mr_arvalid[m] = 1'b1;
    g = 0;
    do begin @(negedge CLK); g++; end while (!mr_arready[m] && g < 200);
    if (!mr_arready[m]) chk("ar_timeout", mr_arready[m], 1'b1);
    ar_cyc = cyc;
    @(posedge CLK); #1 mr_arvalid[m] = 1'b0;
    done = 1'b0; g = 0;
    while (!done && g < 200) begin
      @(negedge CLK); g++;
      if (mr_rvalid[m]) begin
        if (beats == 0) first_d = mr_rdata[m];
        last_d = mr_rdata[m];
        beats++;
        if (mr_rlast[m]) begin done = 1'b1; end_cyc = cyc; end
      end
    end
    if (!done) chk("r_timeout", done, 1'b1);
  endtask

  task automatic wr_txn(input int m, input logic [31:0] addr, input logic [7:0] len,
                        input int seed, input logic [15:0] strb0,
                        output int end_cyc, output logic [1:0] bresp);
    int g, beat;
    end_cyc = -1; bresp = 2'b11;
    mw_awaddr[m] = addr; mw_awlen[m] = len; mw_awvalid[m] = 1'b1;
    g = 0;
    do begin @(negedge CLK); g++; end while (!mw_awready[m] && g < 200);
    if (!mw_awready[m]) chk("aw_timeout", mw_awready[m], 1'b1);
    @(posedge CLK); #1 mw_awvalid[m] = 1'b0;
    beat = 0;
    mw_wdata[m] = wd(seed, 0); mw_wstrb[m] = strb0; mw_wlast[m] = (len == 8'd0);
    mw_wvalid[m] = 1'b1;
    g = 0;
    while (beat <= int'(len) && g < 200) begin
      @(negedge CLK); g++;
      if (mw_wready[m]) begin
        beat++;
        @(posedge CLK); #1;
        if (beat <= int'(len)) begin
          mw_wdata[m] = wd(seed, beat); mw_wstrb[m] = 16'hFFFF;
          mw_wlast[m] = (beat == int'(len));
        end else mw_wvalid[m] = 1'b0;
      end
    end
    mw_wvalid[m] = 1'b0;
    g = 0;
    do begin @(negedge CLK); g++; end while (!mw_bvalid[m] && g < 200);
    if (!mw_bvalid[m]) chk("b_timeout", mw_bvalid[m], 1'b1);
    end_cyc = cyc; bresp = mw_bresp[m];
  endtask

  // ---------------------------------------------------------------- sequence
  int st, a0, a1, e0, e1, n0, n1, ew, g;
  logic [127:0] f0, l0, f1, l1;
  logic [1:0] br;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      mr_araddr[i] = '0; mr_arlen[i] = '0; mr_arvalid[i] = 1'b0;
      mw_awaddr[i] = '0; mw_awlen[i] = '0; mw_awvalid[i] = 1'b0;
      mw_wdata[i] = '0; mw_wstrb[i] = '0; mw_wlast[i] = 1'b0; mw_wvalid[i] = 1'b0;
    end
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_outputs", {sr.arvalid, sr.rready, sw.awvalid, sw.wvalid, sw.bready,
                        m0r.arready, m0r.rvalid, m1r.arready, m1r.rvalid,
                        m0w.awready, m0w.wready, m0w.bvalid,
                        m1w.awready, m1w.wready, m1w.bvalid}, '0);
    chk("rst_state", {dut.r_st, dut.w_st, dut.w_cnt}, {R_IDLE, W_IDLE, 8'd0});
`ifdef AXI_ARB_RR_EN
    chk("rst_rr", {dut.rr_r, dut.rr_w}, 2'b11);
`endif
    RSTn = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Solo read, M0, len 3
    m1_rv = 0; st = cyc;
    fork
      rd_txn(0, 32'h8000_0000, 8'd3, a0, e0, n0, f0, l0);
      begin
        @(negedge CLK);
        chk("rd_bubble", {sr.arvalid, m0r.arready}, 2'b00);
        @(negedge CLK);
        chk("rd_sr_ar", {sr.arvalid, sr.araddr, sr.arlen}, {1'b1, 32'h8000_0000, 8'd3});
      end
    join
    chk("rd_beats", n0, 4);
    chk("rd_first", f0, pat(0));
    chk("rd_last", l0, pat(3));
    chk("rd_lat", e0 - st + 1, 6);
    chk("rd_m1_rvalid", m1_rv, 0);

    // Read tie, twice
    @(posedge CLK); #1;
    st = cyc;
    fork
      rd_txn(0, 32'h1000, 8'd0, a0, e0, n0, f0, l0);
      rd_txn(1, 32'h2000, 8'd0, a1, e1, n1, f1, l1);
    join
    chk("tie1_m0_ar", a0 - st, 1);
    chk("tie1_m1_after", a1 - a0, 3);
    chk("tie1_beats", {n0[7:0], n1[7:0]}, {8'd1, 8'd1});
    @(posedge CLK); #1;
    fork
      rd_txn(0, 32'h1000, 8'd0, a0, e0, n0, f0, l0);
      rd_txn(1, 32'h2000, 8'd0, a1, e1, n1, f1, l1);
    join
    chk("tie2_m1_first", a1 < a0, TIE2_M1_FIRST);

    // Write burst, M1, len 1, partial first strobe
    @(posedge CLK); #1;
    sw_wbeats = 0; m0_bv = 0; st = cyc;
    wr_txn(1, 32'h100, 8'd1, 16, 16'h00FF, ew, br);
    chk("wr_sw_beats", sw_wbeats, 2);
    chk("wr_bresp", br, 2'b00);
    chk("wr_m0_bvalid", m0_bv, 0);
    chk("wr_lat", ew - st + 1, 5);
    @(negedge CLK);
    chk("wr_idle_after_b", dut.w_st, W_IDLE);
    @(posedge CLK); #1;
    rd_txn(1, 32'h100, 8'd1, a1, e1, n1, f1, l1);
    chk("wr_rb_beat0", f1, {32'hA500_0010, 32'hA500_0010, 32'hC0DE_0010, 32'hC0DE_0010});
    chk("wr_rb_beat1", l1, {4{32'hC0DE_0011}});

    // Concurrent M0 read len 7 and M1 write len 7
    @(posedge CLK); #1;
    st = cyc;
    fork
      rd_txn(0, 32'h8000_0000, 8'd7, a0, e0, n0, f0, l0);
      wr_txn(1, 32'h400, 8'd7, 64, 16'hFFFF, ew, br);
    join
    chk("conc_rd_lat", e0 - st + 1, 10);
    chk("conc_wr_lat", ew - st + 1, 11);
    chk("conc_rd_last", {n0[7:0], l0}, {8'd8, pat(7)});
    @(posedge CLK); #1;
    rd_txn(0, 32'h470, 8'd0, a0, e0, n0, f0, l0);
    chk("conc_readback", f0, {4{32'hC0DE_0047}});

    // Blocking: M1 AR arrives while M0 streams data
    @(posedge CLK); #1;
    m1_early = 0; m0_done = 1'b0; mon_blk = 1'b1;
    fork
      begin
        rd_txn(0, 32'h8000_0000, 8'd3, a0, e0, n0, f0, l0);
        m0_done = 1'b1;
      end
      begin
        g = 0;
        do begin @(negedge CLK); g++; end while (!mr_rvalid[0] && g < 50);
        @(posedge CLK); #1;
        rd_txn(1, 32'h2000, 8'd0, a1, e1, n1, f1, l1);
      end
    join
    mon_blk = 1'b0;
    chk("blk_m1_arready", m1_early, 0);
    chk("blk_m1_grant", a1 - e0, 2);

    // Reset during W_DATA with w_cnt = 3
    @(posedge CLK); #1;
    mw_awaddr[0] = 32'h200; mw_awlen[0] = 8'd5; mw_awvalid[0] = 1'b1;
    g = 0;
    do begin @(negedge CLK); g++; end while (!mw_awready[0] && g < 50);
    @(posedge CLK); #1 mw_awvalid[0] = 1'b0;
    mw_wdata[0] = wd(32, 0); mw_wstrb[0] = 16'hFFFF; mw_wlast[0] = 1'b0; mw_wvalid[0] = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_wcnt", {dut.w_st, dut.w_cnt, m0w.wready}, {W_DATA, 8'd3, 1'b1});
    RSTn = 1'b0;
    #1;
    chk("rst_mid_drop", {sw.wvalid, sw.awvalid, sw.bready, m0w.wready, m0w.awready,
                         m0w.bvalid, sr.arvalid, sr.rready}, 8'h00);
    repeat (2) @(posedge CLK);
    mw_wvalid[0] = 1'b0;
    @(negedge CLK); RSTn = 1'b1;
    @(posedge CLK); #1;
    st = cyc;
    rd_txn(0, 32'h0, 8'd0, a0, e0, n0, f0, l0);
    chk("post_rst_read", {n0[7:0], l0}, {8'd1, pat(0)});
    chk("post_rst_lat", e0 - st + 1, 3);

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
